muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit beside the single-cycle ALU in the MIPS execute stage.
- Implements MULT, MULTU, DIV, DIVU with an iterative shift-add multiplier and a restoring divider. Results go into architectural HI/LO registers.
- Handles MFHI/MFLO reads and MTHI/MTLO writes.
- Drives a busy/stall signal so the pipeline holds dependent instructions until the result is ready.

---
 rtl/muldiv_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with architectural HI/LO for the MIPS execute stage.
// Define MULDIV_EARLY_OUT_EN to retire multiplies early once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_FIN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH+1:0]   w_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_mt_ok;

  assign w_signed = ~op[0];
  assign w_neg_a  = w_signed & op_a[WIDTH-1];
  assign w_neg_b  = w_signed & op_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -op_a : op_a;
  assign w_mag_b  = w_neg_b ? -op_b : op_b;

  // Multiply: accumulator upper half gains the multiplicand when the multiplier LSB is set.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: {remainder, quotient} shifts left; a non-borrowing trial subtract commits and sets the quotient bit.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial    = {1'b0, w_rem_sh} - {2'b00, r_opnd};
  assign w_div_next = w_trial[WIDTH+1] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign w_mt_ok = (r_state == S_IDLE) || (r_state == S_FIN);

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0]   w_shamt;
  logic [WIDTH-1:0]   w_live_mask;
  logic               w_mul_early;
  logic [2*WIDTH-1:0] w_acc_sh;

  // Unprocessed multiplier bits occupy acc[r_cnt-1:0].
  assign w_shamt     = CNT_W'(WIDTH) - r_cnt;
  assign w_live_mask = {WIDTH{1'b1}} >> w_shamt;
  assign w_mul_early = ~r_is_div && ((r_acc[WIDTH-1:0] & w_live_mask) == '0);
  assign w_acc_sh    = r_acc >> r_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_mt_ok) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div  <= op[1];
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_dz      <= 1'b0;
            if (op[1] && (op_b == '0)) begin
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_opnd  <= op[1] ? w_mag_b : w_mag_a;
              r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
              r_cnt   <= CNT_W'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
`ifdef MULDIV_EARLY_OUT_EN
            if (w_mul_early) begin
              r_acc   <= w_acc_sh;
              r_cnt   <= '0;
              r_state <= S_FIX;
            end else begin
              r_acc <= r_is_div ? w_div_next : w_mul_next;
              r_cnt <= r_cnt - CNT_W'(1);
              if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
            end
`else
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
`endif
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int unsigned WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        op = '0;
  logic [WIDTH-1:0]  op_a = '0;
  logic [WIDTH-1:0]  op_b = '0;
  logic              flush = 1'b0;
  logic              hi_we = 1'b0;
  logic              lo_we = 1'b0;
  logic [WIDTH-1:0]  wdata = '0;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {HI, LO} from plain 64-bit arithmetic; division truncates toward zero.
  function automatic logic [63:0] ref_result(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (opc)
      2'b00: begin p = sa * sb; return 64'(p); end
      2'b01: begin up = ua * ub; return up; end
      2'b10: begin q = sa / sb; r = sa % sb; return {32'(r), 32'(q)}; end
      default: begin return {32'(ua % ub), 32'(ua / ub)}; end
    endcase
  endfunction

  function automatic int unsigned exp_latency(input logic [1:0] opc, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] mb;
    if (!opc[1]) begin
      mb = (opc == 2'b00 && b[31]) ? -b : b;
      if (mb == '0) return 2;
      for (int i = 31; i >= 0; i--)
        if (mb[i]) return ((i + 3) < (WIDTH + 1)) ? (i + 3) : (WIDTH + 1);
    end
`endif
    return WIDTH + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
    hi_we = 1'b1; wdata = hv; step(); hi_we = 1'b0;
    lo_we = 1'b1; wdata = lv; step(); lo_we = 1'b0;
    m_hi = hv; m_lo = lv;
    check("mthi", 64'(hi), 64'(m_hi));
    check("mtlo", 64'(lo), 64'(m_lo));
  endtask

  task automatic run_op(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input bit mt_hi);
    logic [63:0] r;
    int unsigned lat, e, bad;
    bit dz;
    logic [31:0] wv;
    dz  = opc[1] && (b == '0);
    r   = ref_result(opc, a, b);
    lat = dz ? 0 : exp_latency(opc, b);
    start = 1'b1; op = opc; op_a = a; op_b = b;
    if (mt_hi) begin wv = $urandom; hi_we = 1'b1; wdata = wv; m_hi = wv; end
    step();
    start = 1'b0; hi_we = 1'b0; op_a = $urandom; op_b = $urandom;
    if (mt_hi) check("mt_with_start", 64'(hi), 64'(m_hi));
    e = 0; bad = 0;
    while (!done && e < 200) begin
      if (busy !== 1'b1) bad++;
      if (noise) begin
        start = 1'($urandom_range(0, 1)); op = 2'($urandom);
        hi_we = 1'($urandom_range(0, 1)); lo_we = 1'($urandom_range(0, 1)); wdata = $urandom;
      end
      step();
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      e++;
    end
    check("latency", 64'(e), 64'(lat));
    check("busy_in_flight", 64'(bad), 64'(0));
    check("busy_at_done", 64'(busy), 64'(0));
    if (!dz) begin m_hi = r[63:32]; m_lo = r[31:0]; end
    m_dz = dz;
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("div_zero", 64'(div_zero), 64'(m_dz));
    start = 1'b1; op = 2'b01; op_a = $urandom; op_b = $urandom;
    step();
    start = 1'b0;
    check("fin_start_ignored", 64'({busy, done}), 64'(0));
  endtask

  task automatic run_flush(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                           input int unsigned at);
    int unsigned saw;
    start = 1'b1; op = opc; op_a = a; op_b = b;
    step();
    start = 1'b0;
    for (int i = 1; i <= int'(at); i++) begin
      if (i == 3) begin start = 1'b1; op = 2'b11; op_b = '0; end
      step();
      start = 1'b0;
    end
    check("busy_before_flush", 64'(busy), 64'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw++;
      step();
    end
    check("flush_no_done", 64'(saw), 64'(0));
    check("flush_hi", 64'(hi), 64'(m_hi));
    check("flush_lo", 64'(lo), 64'(m_lo));
    check("flush_dz", 64'(div_zero), 64'(m_dz));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    #10 rst_n = 1'b1;
    step();

    run_op(2'b00, 32'hFFFF_FFFE, 32'h3, 1'b0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    mt_write(32'h11, 32'h22);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(2'b11, 32'd9, 32'd4, 1'b0, 1'b1);
    run_op(2'b10, 32'd1234, 32'd0, 1'b0, 1'b1);
    run_op(2'b00, 32'hFFFF_FFF3, 32'h8000_0000, 1'b1, 1'b0);
    run_flush(2'b00, 32'd6, 32'd7,
`ifdef MULDIV_EARLY_OUT_EN
              2
`else
              10
`endif
              );
    run_flush(2'b10, 32'hFFFF_FF9C, 32'd7, WIDTH);

    start = 1'b1; op = 2'b00; op_a = 32'd6; op_b = 32'd7;
    step();
    start = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_done", 64'(done), 64'(0));
    check("async_rst_dz", 64'(div_zero), 64'(0));
    check("async_rst_hi", 64'(hi), 64'(0));
    check("async_rst_lo", 64'(lo), 64'(0));
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    #2 rst_n = 1'b1;
    step();

    run_op(2'b01, 32'd5, 32'd3, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++)
      run_op(2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
